// File: rtl/md_unit_pkg.sv
// Shared op codes, default latencies and MD-class decode for the multiply/divide unit.
// Optional feature macro: MD_MADD_EN (multiply-accumulate/subtract ops).
package md_unit_pkg;

    localparam int MD_OP_W = 4;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
    localparam logic [MD_OP_W-1:0] MD_MADD  = 4'd7;
    localparam logic [MD_OP_W-1:0] MD_MADDU = 4'd8;
    localparam logic [MD_OP_W-1:0] MD_MSUB  = 4'd9;
    localparam logic [MD_OP_W-1:0] MD_MSUBU = 4'd10;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // Ops that occupy the unit for a multi-cycle latency; decode stalls on these.
    function automatic logic is_md_class(input logic [MD_OP_W-1:0] op);
        logic r;
        r = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`ifdef MD_MADD_EN
        r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
        return r;
    endfunction

    function automatic logic is_div_op(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational datapath of the multiply/divide unit: products, quotients/remainders
// and (with MD_MADD_EN) the HI/LO accumulate; results are captured by md_unit at start.
module md_arith
    import md_unit_pkg::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    input  logic [31:0]        hi_in,
    input  logic [31:0]        lo_in,
    output logic [31:0]        hi_tmp,
    output logic [31:0]        lo_tmp,
    output logic               div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        b_zero;
    logic        div_ovf;
    logic [31:0] b_div;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign b_zero  = (b == 32'd0);
    // Most-negative / -1 overflows the quotient; it is forced to the wrapped result.
    assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign b_div   = (b_zero || div_ovf) ? 32'd1 : b;

    always_comb begin
        if (div_ovf) begin
            quot_s = 32'h8000_0000;
            rem_s  = 32'd0;
        end else begin
            quot_s = $signed(a) / $signed(b_div);
            rem_s  = $signed(a) % $signed(b_div);
        end
    end

    assign quot_u = a / b_div;
    assign rem_u  = a % b_div;

`ifdef MD_MADD_EN
    logic [63:0] acc;
    assign acc = {hi_in, lo_in};
`endif

    always_comb begin
        hi_tmp = hi_in;
        lo_tmp = lo_in;
        div0   = 1'b0;
        case (op)
            MD_MULT:  {hi_tmp, lo_tmp} = prod_s;
            MD_MULTU: {hi_tmp, lo_tmp} = prod_u;
            MD_DIV: begin
                div0 = b_zero;
                if (!b_zero) begin
                    hi_tmp = rem_s;
                    lo_tmp = quot_s;
                end
            end
            MD_DIVU: begin
                div0 = b_zero;
                if (!b_zero) begin
                    hi_tmp = rem_u;
                    lo_tmp = quot_u;
                end
            end
`ifdef MD_MADD_EN
            MD_MADD:  {hi_tmp, lo_tmp} = acc + prod_s;
            MD_MADDU: {hi_tmp, lo_tmp} = acc + prod_u;
            MD_MSUB:  {hi_tmp, lo_tmp} = acc - prod_s;
            MD_MSUBU: {hi_tmp, lo_tmp} = acc - prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs a fixed-latency busy FSM and drives md_busy.
// Optional feature macro: MD_MADD_EN (madd/maddu/msub/msubu, via md_unit_pkg and md_arith).
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               E_md_start,
    input  logic [MD_OP_W-1:0] E_md_op,
    input  logic [31:0]        E_A,
    input  logic [31:0]        E_B,
    output logic               md_busy,
    output logic [31:0]        E_HI,
    output logic [31:0]        E_LO
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_e        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;
    logic [31:0]      hi_tmp_reg;
    logic [31:0]      lo_tmp_reg;
    logic             div0_reg;

    logic [31:0] hi_tmp;
    logic [31:0] lo_tmp;
    logic        div0;
    logic        start_long;

    md_arith u_arith (
        .op     (E_md_op),
        .a      (E_A),
        .b      (E_B),
        .hi_in  (hi_reg),
        .lo_in  (lo_reg),
        .hi_tmp (hi_tmp),
        .lo_tmp (lo_tmp),
        .div0   (div0)
    );

    assign start_long = E_md_start && is_md_class(E_md_op);
    assign md_busy    = start_long || busy_reg;
    assign E_HI       = hi_reg;
    assign E_LO       = lo_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            hi_reg     <= 32'd0;
            lo_reg     <= 32'd0;
            hi_tmp_reg <= 32'd0;
            lo_tmp_reg <= 32'd0;
            div0_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_long) begin
                        // Operands are frozen here; E_A/E_B may change freely while busy.
                        state_reg  <= ST_BUSY;
                        busy_reg   <= 1'b1;
                        cnt_reg    <= is_div_op(E_md_op) ? DIV_LOAD : MULT_LOAD;
                        hi_tmp_reg <= hi_tmp;
                        lo_tmp_reg <= lo_tmp;
                        div0_reg   <= div0;
                    end else if (E_md_start && (E_md_op == MD_MTHI)) begin
                        hi_reg <= E_A;
                    end else if (E_md_start && (E_md_op == MD_MTLO)) begin
                        lo_reg <= E_A;
                    end
                end
                ST_BUSY: begin
                    if (cnt_reg == CNT_ONE) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                        if (!div0_reg) begin
                            hi_reg <= hi_tmp_reg;
                            lo_reg <= lo_tmp_reg;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_ONE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized ops against an arithmetic model.
// Honors MD_MADD_EN to decide whether the accumulate ops are live or no-ops.
module tb_md_unit;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        E_md_start = 1'b0;
    logic [3:0]  E_md_op = 4'd0;
    logic [31:0] E_A = 32'd0;
    logic [31:0] E_B = 32'd0;
    logic        md_busy;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    always #5 clk = ~clk;

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk        (clk),
        .reset      (reset),
        .E_md_start (E_md_start),
        .E_md_op    (E_md_op),
        .E_A        (E_A),
        .E_B        (E_B),
        .md_busy    (md_busy),
        .E_HI       (E_HI),
        .E_LO       (E_LO)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: applies the op's architectural effect to hi_m/lo_m, returns busy latency.
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int lat);
        longint sa, sb, ma, mb, q, r;
        logic [63:0] p;
        lat = 0;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            OP_MULT: begin
                p = sa * sb;
                {hi_m, lo_m} = p;
                lat = MULT_N;
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                {hi_m, lo_m} = p;
                lat = MULT_N;
            end
            OP_DIV: begin
                lat = DIV_N;
                if (b != 32'd0) begin
                    ma = (sa < 0) ? -sa : sa;
                    mb = (sb < 0) ? -sb : sb;
                    q = ma / mb;
                    r = ma % mb;
                    if ((sa < 0) != (sb < 0)) q = -q;
                    if (sa < 0) r = -r;
                    lo_m = 32'(q);
                    hi_m = 32'(r);
                end
            end
            OP_DIVU: begin
                lat = DIV_N;
                if (b != 32'd0) begin
                    lo_m = a / b;
                    hi_m = a % b;
                end
            end
            OP_MTHI: hi_m = a;
            OP_MTLO: lo_m = a;
`ifdef MD_MADD_EN
            OP_MADD:  begin p = sa * sb; {hi_m, lo_m} = {hi_m, lo_m} + p; lat = MULT_N; end
            OP_MADDU: begin p = {32'd0, a} * {32'd0, b}; {hi_m, lo_m} = {hi_m, lo_m} + p; lat = MULT_N; end
            OP_MSUB:  begin p = sa * sb; {hi_m, lo_m} = {hi_m, lo_m} - p; lat = MULT_N; end
            OP_MSUBU: begin p = {32'd0, a} * {32'd0, b}; {hi_m, lo_m} = {hi_m, lo_m} - p; lat = MULT_N; end
`endif
            default: ;
        endcase
    endtask

    // Issues one op, checks busy every cycle, HI/LO held until commit, then the new values.
    // poke issues an extra start mid-operation, which must be ignored.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit poke);
        logic [31:0] old_hi, old_lo;
        int lat;
        old_hi = hi_m;
        old_lo = lo_m;
        model_op(op, a, b, lat);
        @(negedge clk);
        E_md_start = 1'b1;
        E_md_op = op;
        E_A = a;
        E_B = b;
        #1;
        check_val("busy_at_start", {63'd0, md_busy}, {63'd0, lat != 0});
        @(posedge clk);
        #1;
        E_md_start = 1'b0;
        E_md_op = 4'($urandom);
        E_A = $urandom;
        E_B = $urandom;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            E_md_start = 1'b0;
            check_val("busy_hold", {63'd0, md_busy}, 64'd1);
            check_val("hilo_hold", {E_HI, E_LO}, {old_hi, old_lo});
            if (poke && i == 2) begin
                E_md_start = 1'b1;
                E_md_op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_MTHI;
                E_A = $urandom;
                E_B = $urandom;
            end
        end
        @(negedge clk);
        check_val("busy_done", {63'd0, md_busy}, 64'd0);
        check_val("hi", {32'd0, E_HI}, {32'd0, hi_m});
        check_val("lo", {32'd0, E_LO}, {32'd0, lo_m});
        $display("txn op=%0d a=%h b=%h poke=%0d busy=%0d hi=%h lo=%h", op, a, b, poke, lat, E_HI, E_LO);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'd1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1 reset = 1'b1;
        #1;
        check_val("rst_busy", {63'd0, md_busy}, 64'd0);
        check_val("rst_hi", {32'd0, E_HI}, 64'd0);
        check_val("rst_lo", {32'd0, E_LO}, 64'd0);
        E_md_start = 1'b1;
        E_md_op = OP_MULT;
        #1;
        check_val("rst_busy_start", {63'd0, md_busy}, 64'd1);
        E_md_start = 1'b0;
        E_md_op = OP_NONE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
        check_val("kat_mult", {E_HI, E_LO}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0);
        check_val("kat_divu", {E_HI, E_LO}, {32'd2, 32'd14});
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check_val("kat_div", {E_HI, E_LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check_val("kat_div_ovf", {E_HI, E_LO}, {32'd0, 32'h8000_0000});
        run_op(OP_MTHI, 32'h1234, 32'd0, 1'b0);
        run_op(OP_MTLO, 32'h5678, 32'd0, 1'b0);
        run_op(OP_DIVU, 32'd99, 32'd0, 1'b0);
        check_val("kat_div0", {E_HI, E_LO}, {32'h1234, 32'h5678});
        run_op(OP_MULT, 32'd3, 32'd4, 1'b1);
        check_val("kat_poke", {E_HI, E_LO}, 64'd12);
        run_op(OP_NONE, 32'hDEAD, 32'hBEEF, 1'b0);
        run_op(4'd13, 32'hDEAD, 32'hBEEF, 1'b0);

        run_op(OP_MTHI, 32'd0, 32'd0, 1'b0);
        run_op(OP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op(OP_MADDU, 32'd1, 32'd1, 1'b0);
`ifdef MD_MADD_EN
        check_val("kat_maddu", {E_HI, E_LO}, {32'd1, 32'd0});
`else
        check_val("kat_maddu_noop", {E_HI, E_LO}, {32'd0, 32'hFFFF_FFFF});
`endif

        for (int t = 0; t < 60; t++) begin
            run_op(4'($urandom_range(0, 15)), rand_operand(), rand_operand(),
                   $urandom_range(0, 3) == 0);
        end

        // Reset mid-operation: results are abandoned, nothing commits afterwards.
        run_op(OP_MTHI, 32'hAAAA_0000, 32'd0, 1'b0);
        run_op(OP_MTLO, 32'h0000_5555, 32'd0, 1'b0);
        @(negedge clk);
        E_md_start = 1'b1;
        E_md_op = OP_MULT;
        E_A = 32'd6;
        E_B = 32'd7;
        @(posedge clk);
        #1 E_md_start = 1'b0;
        @(posedge clk);
        #1;
        check_val("pre_rst_busy", {63'd0, md_busy}, 64'd1);
        #1 reset = 1'b1;
        #1;
        check_val("mid_rst_busy", {63'd0, md_busy}, 64'd0);
        check_val("mid_rst_hilo", {E_HI, E_LO}, 64'd0);
        hi_m = 32'd0;
        lo_m = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_val("post_rst_busy", {63'd0, md_busy}, 64'd0);
            check_val("post_rst_hilo", {E_HI, E_LO}, {hi_m, lo_m});
        end
        $display("txn reset-mid-mult hi=%h lo=%h", E_HI, E_LO);

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check_val("kat_multu", {E_HI, E_LO}, 64'hFFFF_FFFE_0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit in the E stage of the P6 five-stage MIPS pipeline.
- Services mult/multu/div/divu/mthi/mtlo and owns the HI/LO registers.
- Answers the decode stage's MD_yes stall request: decode stalls any MD-class instruction while md_busy is high.
- Results become readable (mfhi/mflo via E_HI/E_LO) only after the fixed latency completes.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd-class when enabled).
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- E_md_start  input  1  one-cycle request, qualified with E_md_op.
- E_md_op  input  4  operation code (codes in macros.v).
- E_A  input  32  forwarded rs value.
- E_B  input  32  forwarded rt value.
- md_busy  output  1  combinational: (E_md_start & op is mult/div class) | busy_q. Feeds the decode stall logic.
- E_HI  output  32  current HI register.
- E_LO  output  32  current LO register.

Behaviour:
- Reset (asynchronous, active-high):
  - HI=0, LO=0, state=IDLE, cnt=0.
  - busy_q=0; md_busy=0 unless a start is presented.
  - Reset mid-operation abandons the result with no later commit.
- States:
  - IDLE -> BUSY on a rising edge with E_md_start=1 and op in {MULT, MULTU, DIV, DIVU}.
  - cnt loads MULT_CYCLES or DIV_CYCLES.
  - Operands are evaluated at the start edge into hi_tmp/lo_tmp (64-bit product, or quotient/remainder); later changes on E_A/E_B have no effect.
- BUSY:
  - cnt decrements each edge.
  - On the edge where cnt==1: HI<=hi_tmp, LO<=lo_tmp, busy_q<=0, state<=IDLE.
  - busy_q is high for exactly N cycles after the start edge. New HI/LO is visible in the first cycle busy_q is low.
- MTHI/MTLO:
  - Accepted in IDLE only; writes E_A into HI or LO at the start edge.
  - No busy cycles; md_busy does not assert for these ops.
- Start while BUSY: ignored; state and temps untouched. Decode stalling guarantees this does not happen; the bench checks it anyway.
- Start with op=MD_NONE or an unknown code: no-op.
- Arithmetic:
  - MULT: signed 32x32 -> 64; HI=upper, LO=lower.
  - MULTU: unsigned 32x32 -> 64.
  - DIV: signed. LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - DIVU: unsigned.
  - Divisor 0 (div or divu): full busy latency still taken; HI/LO left unchanged at commit.
- Read/commit collision: reading E_HI/E_LO on the same cycle as a commit edge returns the pre-commit value. There is no internal bypass; the pipeline stall covers this case.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined:
  - Adds MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU.
  - Each computes {HI,LO} +/- (E_A*E_B), signed or unsigned, modulo 2^64.
  - {HI,LO} is captured at the start edge; latency is MULT_CYCLES; md_busy asserts for these ops.
- Undefined: these codes are treated as no-ops; no extra accumulator adder is synthesized.

Decomposition:
- macros.v (shared):
  - Op codes: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6, MD_MADD=7, MD_MADDU=8, MD_MSUB=9, MD_MSUBU=10.
  - Default cycle constants.
  - An is-MD-class helper macro, shared with the decode Controller for MD_yes.
- Sub-module md_arith: combinational. Takes op, A, B, old HI/LO; returns hi_tmp/lo_tmp and a div0 flag.
- md_unit keeps the FSM, counter and HI/LO registers.

Test Plan:
- mult, A=0xFFFFFFFD (-3), B=5 -> md_busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- divu, A=100, B=7 -> busy 10 cycles; then LO=14, HI=2.
- div, A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Sequence:
  - mthi 0x1234 then mtlo 0x5678 -> no busy; HI=0x1234, LO=0x5678.
  - divu by 0 -> after 10 cycles HI/LO still 0x1234/0x5678.
  - Second start during BUSY -> ignored.
- Reset mid-operation: mult 6*7 started, reset asserted at cycle 2 -> HI=LO=0 and busy=0 immediately; no commit afterwards.
- With MD_MADD_EN: HI=0, LO=0xFFFFFFFF, then maddu 1*1 -> HI=1, LO=0 after 5 cycles.
